text_cell_fetcher: RTL and testbench

Upstream feeder for the font shape renderer. Walks the character text buffer in raster order, looks up each cell's glyph in the font ROM and its colours in the console palette, and offers the renderer one fully formed `CharGrid_t` with its framebuffer base address and cursor flag per `fontReady` pulse. The next cell is prefetched while the renderer is still writing the current one. Sits between the console text RAM / font ROM and the renderer, and is started once per screen refresh.

---
 rtl/text_cell_fetcher.sv | 265 ++++++++++++++++++++++++++
 tb/tb_text_cell_fetcher.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cell_fetcher.sv
// text_cell_fetcher: walks the console text buffer in raster order and
// turns each cell into a glyph-plus-colours CharGrid_t for the renderer.
// The next cell is fetched into a staging register while the renderer is
// still drawing the current one.

package text_cell_fetcher_pkg;

    localparam int PIXEL_PER_CHARACTER = 128;

    typedef logic [19:0] SramAddress_t;
    typedef logic [15:0] SramData_t;

    typedef struct packed {
        logic [PIXEL_PER_CHARACTER-1:0] shape;
        SramData_t                      fg;
        SramData_t                      bg;
    } CharGrid_t;

    // 16-colour console palette, RGB565.
    localparam SramData_t CONSOLE_PALETTE [16] = '{
        16'h0000, 16'h0015, 16'h0540, 16'h0555,
        16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
        16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
        16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TEXT  = 3'd1,
        ST_FONT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DRAIN = 3'd5
    } fetch_state_t;

endpackage

module text_cell_fetcher
    import text_cell_fetcher_pkg::*;
#(
    parameter int           CONSOLE_COLUMNS      = 80,
    parameter int           CONSOLE_LINES        = 30,
    parameter int           WIDTH_PER_CHARACTER  = 8,
    parameter int           HEIGHT_PER_CHARACTER = 16,
    parameter SramAddress_t FRAME_BASE           = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           cursorEnable,
    input  logic [4:0]                     cursorRow,
    input  logic [6:0]                     cursorCol,
    output logic [11:0]                    textAddress,
    input  logic [15:0]                    textData,
    output logic [7:0]                     fontAddress,
    input  logic [PIXEL_PER_CHARACTER-1:0] fontShape,
    output CharGrid_t                      grid,
    output SramAddress_t                   baseAddress,
    output logic                           currentCursor,
    output logic                           fontReady,
    input  logic                           rendererDone,
    output logic                           busy,
    output logic                           frameDone,
    output logic [2:0]                     dbgState,
    output logic                           dbgStagedValid,
    output logic                           dbgAwaitDrop
);

    localparam SramAddress_t ROW_STRIDE =
        SramAddress_t'(CONSOLE_COLUMNS * WIDTH_PER_CHARACTER * HEIGHT_PER_CHARACTER);
    localparam SramAddress_t COL_STRIDE = SramAddress_t'(WIDTH_PER_CHARACTER);
    localparam logic [4:0]   LAST_ROW   = 5'(CONSOLE_LINES - 1);
    localparam logic [6:0]   LAST_COL   = 7'(CONSOLE_COLUMNS - 1);

    fetch_state_t state_q, state_d;

    // Fetch position and its incrementally maintained addresses.
    logic [4:0]   row_q, row_d;
    logic [6:0]   col_q, col_d;
    logic [11:0]  text_addr_q, text_addr_d;
    SramAddress_t row_base_q, row_base_d;
    SramAddress_t cell_base_q, cell_base_d;

    // Text word fields captured in FONT.
    logic [7:0]   char_q, char_d;
    logic [3:0]   fg_idx_q, fg_idx_d;
    logic [3:0]   bg_idx_q, bg_idx_d;

    // Staging set (prefetched cell).
    CharGrid_t    stg_grid_q, stg_grid_d;
    SramAddress_t stg_base_q, stg_base_d;
    logic         stg_cursor_q, stg_cursor_d;
    logic         staged_valid_q, staged_valid_d;

    // Output set, changes only on a transfer.
    CharGrid_t    grid_q, grid_d;
    SramAddress_t base_q, base_d;
    logic         cursor_q, cursor_d;

    logic         await_drop_q, await_drop_d;
    logic         frame_done_q, frame_done_d;

    logic         transfer;
    logic         last_cell;

    // Handshake: a staged cell moves to the renderer in any cycle where it is
    // valid and rendererDone is high, unless the renderer has not yet dropped
    // rendererDone since the previous hand-off (awaitDrop). fontReady marks
    // that cycle; the new outputs are visible from the next cycle onward.
    assign transfer  = staged_valid_q && rendererDone && !await_drop_q;
    assign last_cell = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            col_q          <= '0;
            text_addr_q    <= '0;
            row_base_q     <= FRAME_BASE;
            cell_base_q    <= FRAME_BASE;
            char_q         <= '0;
            fg_idx_q       <= '0;
            bg_idx_q       <= '0;
            stg_grid_q     <= '0;
            stg_base_q     <= FRAME_BASE;
            stg_cursor_q   <= 1'b0;
            staged_valid_q <= 1'b0;
            grid_q         <= '0;
            base_q         <= FRAME_BASE;
            cursor_q       <= 1'b0;
            await_drop_q   <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            text_addr_q    <= text_addr_d;
            row_base_q     <= row_base_d;
            cell_base_q    <= cell_base_d;
            char_q         <= char_d;
            fg_idx_q       <= fg_idx_d;
            bg_idx_q       <= bg_idx_d;
            stg_grid_q     <= stg_grid_d;
            stg_base_q     <= stg_base_d;
            stg_cursor_q   <= stg_cursor_d;
            staged_valid_q <= staged_valid_d;
            grid_q         <= grid_d;
            base_q         <= base_d;
            cursor_q       <= cursor_d;
            await_drop_q   <= await_drop_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Next-state logic: fetch sequencing, staging, transfer and position advance.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        text_addr_d    = text_addr_q;
        row_base_d     = row_base_q;
        cell_base_d    = cell_base_q;
        char_d         = char_q;
        fg_idx_d       = fg_idx_q;
        bg_idx_d       = bg_idx_q;
        stg_grid_d     = stg_grid_q;
        stg_base_d     = stg_base_q;
        stg_cursor_d   = stg_cursor_q;
        staged_valid_d = staged_valid_q;
        grid_d         = grid_q;
        base_d         = base_q;
        cursor_d       = cursor_q;
        await_drop_d   = await_drop_q;
        frame_done_d   = 1'b0;

        // awaitDrop arms on a hand-off and disarms once rendererDone goes low.
        if (transfer) begin
            await_drop_d = 1'b1;
        end else if (!rendererDone) begin
            await_drop_d = 1'b0;
        end

        if (transfer) begin
            grid_d         = stg_grid_q;
            base_d         = stg_base_q;
            cursor_d       = stg_cursor_q;
            staged_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d       = '0;
                    col_d       = '0;
                    text_addr_d = '0;
                    row_base_d  = FRAME_BASE;
                    cell_base_d = FRAME_BASE;
                    state_d     = ST_TEXT;
                end
            end
            ST_TEXT: begin
                state_d = ST_FONT;
            end
            ST_FONT: begin
                char_d   = textData[7:0];
                fg_idx_d = textData[11:8];
                bg_idx_d = textData[15:12];
                state_d  = ST_CAPT;
            end
            ST_CAPT: begin
                stg_grid_d.shape = fontShape;
                stg_grid_d.fg    = CONSOLE_PALETTE[fg_idx_q];
                stg_grid_d.bg    = CONSOLE_PALETTE[bg_idx_q];
                stg_base_d       = cell_base_q;
                stg_cursor_d     = cursorEnable && (row_q == cursorRow) && (col_q == cursorCol);
                staged_valid_d   = 1'b1;
                state_d          = ST_HOLD;
            end
            ST_HOLD: begin
                if (transfer) begin
                    if (last_cell) begin
                        state_d = ST_DRAIN;
                    end else begin
                        text_addr_d = text_addr_q + 12'd1;
                        if (col_q == LAST_COL) begin
                            col_d       = '0;
                            row_d       = row_q + 5'd1;
                            row_base_d  = row_base_q + ROW_STRIDE;
                            cell_base_d = row_base_q + ROW_STRIDE;
                        end else begin
                            col_d       = col_q + 7'd1;
                            cell_base_d = cell_base_q + COL_STRIDE;
                        end
                        state_d = ST_TEXT;
                    end
                end
            end
            ST_DRAIN: begin
                if (!await_drop_q && rendererDone) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The font ROM sees the char code straight from the text word in FONT so
    // the glyph arrives in CAPT; otherwise it holds the last captured code.
    assign fontAddress    = (state_q == ST_FONT) ? textData[7:0] : char_q;
    assign textAddress    = text_addr_q;
    assign grid           = grid_q;
    assign baseAddress    = base_q;
    assign currentCursor  = cursor_q;
    assign fontReady      = transfer;
    assign busy           = (state_q != ST_IDLE);
    assign frameDone      = frame_done_q;
    assign dbgState       = state_q;
    assign dbgStagedValid = staged_valid_q;
    assign dbgAwaitDrop   = await_drop_q;

endmodule

// File: tb/tb_text_cell_fetcher.sv
// Bench for text_cell_fetcher: synchronous text RAM / font ROM models, a
// renderer model driving rendererDone, and a cell-index reference model.

module tb_text_cell_fetcher;
    import text_cell_fetcher_pkg::*;

    localparam int COLS  = 80;
    localparam int LINES = 30;
    localparam int CW    = 8;
    localparam int CH    = 16;
    localparam int FB    = 'h4000;
    localparam int CELLS = COLS * LINES;

    logic                           clk;
    logic                           rst_n;
    logic                           start;
    logic                           cursorEnable;
    logic [4:0]                     cursorRow;
    logic [6:0]                     cursorCol;
    logic [11:0]                    textAddress;
    logic [15:0]                    textData;
    logic [7:0]                     fontAddress;
    logic [PIXEL_PER_CHARACTER-1:0] fontShape;
    CharGrid_t                      grid;
    SramAddress_t                   baseAddress;
    logic                           currentCursor;
    logic                           fontReady;
    logic                           rendererDone;
    logic                           busy;
    logic                           frameDone;
    logic [2:0]                     dbgState;
    logic                           dbgStagedValid;
    logic                           dbgAwaitDrop;

    text_cell_fetcher #(
        .CONSOLE_COLUMNS      (COLS),
        .CONSOLE_LINES        (LINES),
        .WIDTH_PER_CHARACTER  (CW),
        .HEIGHT_PER_CHARACTER (CH),
        .FRAME_BASE           (SramAddress_t'(FB))
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cursorEnable   (cursorEnable),
        .cursorRow      (cursorRow),
        .cursorCol      (cursorCol),
        .textAddress    (textAddress),
        .textData       (textData),
        .fontAddress    (fontAddress),
        .fontShape      (fontShape),
        .grid           (grid),
        .baseAddress    (baseAddress),
        .currentCursor  (currentCursor),
        .fontReady      (fontReady),
        .rendererDone   (rendererDone),
        .busy           (busy),
        .frameDone      (frameDone),
        .dbgState       (dbgState),
        .dbgStagedValid (dbgStagedValid),
        .dbgAwaitDrop   (dbgAwaitDrop)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: data valid one cycle after the address.
    logic [15:0]                    text_mem  [4096];
    logic [PIXEL_PER_CHARACTER-1:0] glyph_mem [256];
    always @(posedge clk) begin
        textData  <= text_mem[textAddress];
        fontShape <= glyph_mem[fontAddress];
    end

    int checks;
    int errors;
    int cyc;
    int start_cyc;
    int rend_len;
    int rend_cnt;
    bit pend_drop;
    bit ready_prev;
    int fd_count;
    int fd_cyc;
    int overlap;
    logic cur_en;
    int   cur_r;
    int   cur_c;

    CharGrid_t    obs_grid_q [$];
    SramAddress_t obs_base_q [$];
    logic         obs_cur_q  [$];
    int           ready_cyc_q[$];
    logic         held_cur_q [$];

    // Reference model: everything derived from the linear cell index.
    function automatic CharGrid_t model_grid(input int i);
        logic [15:0] w;
        CharGrid_t   g;
        w       = text_mem[i];
        g.shape = glyph_mem[w[7:0]];
        g.fg    = CONSOLE_PALETTE[w[11:8]];
        g.bg    = CONSOLE_PALETTE[w[15:12]];
        return g;
    endfunction

    function automatic SramAddress_t model_base(input int i);
        return SramAddress_t'(FB + (i / COLS) * (COLS * CW * CH) + (i % COLS) * CW);
    endfunction

    function automatic logic model_cursor(input int i);
        return cur_en && ((i / COLS) == cur_r) && ((i % COLS) == cur_c);
    endfunction

    // One clock of the renderer model plus observation of the fetcher.
    task automatic tick();
        @(negedge clk);
        if (pend_drop) begin
            rendererDone = 1'b0;
            rend_cnt     = rend_len;
            pend_drop    = 1'b0;
        end else if (!rendererDone) begin
            if (rend_cnt <= 1) rendererDone = 1'b1;
            else rend_cnt--;
        end
        #1;
        cyc++;
        if (ready_prev) begin
            obs_grid_q.push_back(grid);
            obs_base_q.push_back(baseAddress);
            obs_cur_q.push_back(currentCursor);
        end
        if (fontReady) begin
            pend_drop = 1'b1;
            ready_cyc_q.push_back(cyc);
            held_cur_q.push_back(currentCursor);
        end
        if (frameDone) begin
            fd_count++;
            fd_cyc = cyc;
            if (fontReady) overlap++;
        end
        ready_prev = fontReady;
    endtask

    task automatic clear_obs();
        obs_grid_q.delete();
        obs_base_q.delete();
        obs_cur_q.delete();
        ready_cyc_q.delete();
        held_cur_q.delete();
        fd_count = 0;
        overlap  = 0;
    endtask

    task automatic reset_dut();
        rst_n        = 1'b0;
        start        = 1'b0;
        rendererDone = 1'b1;
        pend_drop    = 1'b0;
        ready_prev   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        tick();
    endtask

    task automatic start_pass();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_cells(input int n, input int budget, output bit timed_out);
        int k;
        k         = 0;
        timed_out = 1'b0;
        while (obs_base_q.size() < n) begin
            if (k >= budget) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start        = 1'($urandom_range(0, 1));
            cursorEnable = 1'($urandom_range(0, 1));
            cursorRow    = 5'($urandom_range(0, 31));
            cursorCol    = 7'($urandom_range(0, 127));
            rendererDone = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (busy !== 1'b0 || fontReady !== 1'b0 || frameDone !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags: busy=%b fontReady=%b frameDone=%b, required 0/0/0", busy, fontReady, frameDone);
            end
        end
        checks++;
        if (grid !== CharGrid_t'(0)) begin
            errors++; $display("FAIL reset_grid: got %h, required 0", grid);
        end
        checks++;
        if (baseAddress !== SramAddress_t'(FB)) begin
            errors++; $display("FAIL reset_base: got %h, required %h", baseAddress, FB);
        end
        checks++;
        if (currentCursor !== 1'b0) begin
            errors++; $display("FAIL reset_cursor: got %b, required 0", currentCursor);
        end
        checks++;
        if (textAddress !== 12'd0 || fontAddress !== 8'd0) begin
            errors++; $display("FAIL reset_addr: text=%h font=%h, required 0/0", textAddress, fontAddress);
        end
        checks++;
        if (dbgState !== 3'd0 || dbgStagedValid !== 1'b0 || dbgAwaitDrop !== 1'b0) begin
            errors++; $display("FAIL reset_internal: state=%0d staged=%b await=%b, required 0/0/0", dbgState, dbgStagedValid, dbgAwaitDrop);
        end
        @(negedge clk);
        start        = 1'b0;
        rendererDone = 1'b1;
        cursorEnable = 1'b0;
        rst_n        = 1'b1;
        pend_drop    = 1'b0;
        ready_prev   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL idle_busy: cycle %0d busy=%b, required 0", i, busy);
            end
        end
    endtask

    task automatic test_first_cell();
        logic [PIXEL_PER_CHARACTER-1:0] p;
        CharGrid_t exp_g;
        bit to;
        p = {$urandom, $urandom, $urandom, $urandom};
        text_mem[0]     = 16'h2341;
        glyph_mem[8'h41] = p;
        exp_g.shape = p;
        exp_g.fg    = CONSOLE_PALETTE[3];
        exp_g.bg    = CONSOLE_PALETTE[2];
        cur_en   = 1'b0;
        cursorEnable = 1'b0;
        rend_len = 3;
        reset_dut();
        start_pass();
        run_until_cells(2, 200, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL first_timeout: got %0d cells, required 2", obs_base_q.size());
            return;
        end
        checks++;
        if (ready_cyc_q[0] !== start_cyc + 4) begin
            errors++; $display("FAIL first_latency: fontReady at +%0d, required +4", ready_cyc_q[0] - start_cyc);
        end
        checks++;
        if (obs_grid_q[0] !== exp_g) begin
            errors++; $display("FAIL first_grid: got %h, required %h", obs_grid_q[0], exp_g);
        end
        checks++;
        if (obs_base_q[0] !== SramAddress_t'(FB)) begin
            errors++; $display("FAIL first_base: got %h, required %h", obs_base_q[0], FB);
        end
        checks++;
        if (obs_base_q[1] !== SramAddress_t'(FB + 8) || obs_grid_q[1] !== model_grid(1)) begin
            errors++; $display("FAIL second_cell: base %h grid %h, required base %h grid %h",
                               obs_base_q[1], obs_grid_q[1], FB + 8, model_grid(1));
        end
    endtask

    task automatic test_renderer_model();
        bit to;
        cur_en   = 1'b0;
        rend_len = 130;
        reset_dut();
        start_pass();
        run_until_cells(82, 82 * 160, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL render_timeout: got %0d cells, required 82", obs_base_q.size());
            return;
        end
        for (int i = 0; i < 82; i++) begin
            checks++;
            if (obs_grid_q[i] !== model_grid(i) || obs_base_q[i] !== model_base(i) || obs_cur_q[i] !== 1'b0) begin
                errors++; $display("FAIL render_cell %0d: base %h grid %h, required base %h grid %h",
                                   i, obs_base_q[i], obs_grid_q[i], model_base(i), model_grid(i));
            end
        end
        for (int i = 0; i + 1 < ready_cyc_q.size(); i++) begin
            checks++;
            if (ready_cyc_q[i + 1] - ready_cyc_q[i] <= rend_len) begin
                errors++; $display("FAIL render_spacing %0d: gap %0d cycles, required > %0d", i, ready_cyc_q[i + 1] - ready_cyc_q[i], rend_len);
            end
        end
        checks++;
        if (obs_base_q[80] !== SramAddress_t'(FB + 10240)) begin
            errors++; $display("FAIL row1_base: got %h, required %h", obs_base_q[80], FB + 10240);
        end
    endtask

    task automatic test_cursor();
        bit to;
        int seen;
        cur_en = 1'b1; cur_r = 2; cur_c = 5;
        cursorEnable = 1'b1; cursorRow = 5'd2; cursorCol = 7'd5;
        rend_len = 2;
        reset_dut();
        start_pass();
        run_until_cells(170, 4000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL cursor_timeout: got %0d cells, required 170", obs_base_q.size());
            return;
        end
        for (int i = 0; i < 170; i++) begin
            checks++;
            if (obs_cur_q[i] !== model_cursor(i)) begin
                errors++; $display("FAIL cursor_cell %0d: got %b, required %b", i, obs_cur_q[i], model_cursor(i));
            end
        end
        checks++;
        if (held_cur_q[166] !== 1'b1 || held_cur_q[165] !== 1'b0) begin
            errors++; $display("FAIL cursor_hold: at pulses 165/166 got %b/%b, required 0/1", held_cur_q[165], held_cur_q[166]);
        end
        cur_en = 1'b0;
        cursorEnable = 1'b0;
        reset_dut();
        start_pass();
        run_until_cells(200, 4000, to);
        seen = 0;
        foreach (obs_cur_q[i]) if (obs_cur_q[i] !== 1'b0) seen++;
        foreach (held_cur_q[i]) if (held_cur_q[i] !== 1'b0) seen++;
        checks++;
        if (to || seen != 0) begin
            errors++; $display("FAIL cursor_disabled: timeout=%0d asserted %0d times, required 0/0", to, seen);
        end
    endtask

    task automatic test_full_pass();
        int k;
        int bad;
        cur_en = 1'b1;
        cur_r  = $urandom_range(0, LINES - 1);
        cur_c  = $urandom_range(0, COLS - 1);
        cursorEnable = 1'b1;
        cursorRow    = 5'(cur_r);
        cursorCol    = 7'(cur_c);
        rend_len = 2;
        reset_dut();
        start_pass();
        k = 0;
        while (fd_count == 0 && k < 30000) begin
            if (ready_cyc_q.size() == 1000 && ready_prev) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
            k++;
        end
        checks++;
        if (fd_count == 0) begin
            errors++; $display("FAIL full_timeout: %0d pulses seen, frameDone missing", ready_cyc_q.size());
            return;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_busy_end: got %b, required 0", busy);
        end
        repeat (20) tick();
        checks++;
        if (ready_cyc_q.size() != CELLS || obs_base_q.size() != CELLS) begin
            errors++; $display("FAIL full_count: got %0d pulses, required %0d", ready_cyc_q.size(), CELLS);
            return;
        end
        bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            checks++;
            if (obs_grid_q[i] !== model_grid(i) || obs_base_q[i] !== model_base(i) || obs_cur_q[i] !== model_cursor(i)) begin
                errors++;
                if (bad < 10) $display("FAIL full_cell %0d: base %h cur %b grid %h, required base %h cur %b grid %h",
                                       i, obs_base_q[i], obs_cur_q[i], obs_grid_q[i], model_base(i), model_cursor(i), model_grid(i));
                bad++;
            end
        end
        checks++;
        if (obs_base_q[CELLS - 1] !== SramAddress_t'(FB + 29 * 10240 + 79 * 8)) begin
            errors++; $display("FAIL last_base: got %h, required %h", obs_base_q[CELLS - 1], FB + 29 * 10240 + 79 * 8);
        end
        checks++;
        if (fd_count != 1 || overlap != 0 || fd_cyc <= ready_cyc_q[CELLS - 1]) begin
            errors++; $display("FAIL frame_done: count %0d overlap %0d at %0d vs last ready %0d, required 1/0/later",
                               fd_count, overlap, fd_cyc, ready_cyc_q[CELLS - 1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_idle_after: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_pass();
        bit to;
        cur_en = 1'b0;
        cursorEnable = 1'b0;
        rend_len = 2;
        reset_dut();
        start_pass();
        run_until_cells(500, 5000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL mid_timeout: got %0d cells, required 500", obs_base_q.size());
            return;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grid !== CharGrid_t'(0) || baseAddress !== SramAddress_t'(FB) || currentCursor !== 1'b0
            || fontReady !== 1'b0 || busy !== 1'b0 || dbgState !== 3'd0) begin
            errors++; $display("FAIL mid_async_reset: base %h cur %b ready %b busy %b state %0d, required %h/0/0/0/0",
                               baseAddress, currentCursor, fontReady, busy, dbgState, FB);
        end
        fd_count = 0;
        repeat (5) tick();
        checks++;
        if (fd_count != 0) begin
            errors++; $display("FAIL mid_no_frame_done: got %0d pulses, required 0", fd_count);
        end
        reset_dut();
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || ready_cyc_q.size() != 0) begin
            errors++; $display("FAIL mid_no_restart: busy %b pulses %0d, required 0/0", busy, ready_cyc_q.size());
        end
        start_pass();
        run_until_cells(2, 200, to);
        checks++;
        if (to || obs_base_q[0] !== SramAddress_t'(FB) || obs_grid_q[0] !== model_grid(0) || obs_base_q[1] !== SramAddress_t'(FB + 8)) begin
            errors++; $display("FAIL mid_restart: timeout %0d, base %h, required base %h at cell 0", to, obs_base_q.size() > 0 ? obs_base_q[0] : '0, FB);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; rendererDone = 1'b1;
        cursorEnable = 1'b0; cursorRow = '0; cursorCol = '0;
        pend_drop = 1'b0; ready_prev = 1'b0; rend_len = 2; rend_cnt = 0;
        fd_count = 0; fd_cyc = 0; overlap = 0;
        cur_en = 1'b0; cur_r = 0; cur_c = 0;
        for (int i = 0; i < 4096; i++) text_mem[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) glyph_mem[i] = {$urandom, $urandom, $urandom, $urandom};

        test_reset();
        test_first_cell();
        test_renderer_model();
        test_cursor();
        test_full_pass();
        test_reset_mid_pass();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
